des_round_ctrl: RTL and testbench

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

---
 rtl/des_round_ctrl_if.sv | 43 ++++
 rtl/des_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_des_round_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// des_round_ctrl_if
// Groups the DES round-controller signals. The controller takes the slave
// modport. The master modport is for the surrounding logic: the block source,
// the external round function that drives F_OUT, and the result consumer.
//
//   START      : request to load one block (master -> slave)
//   MODE       : 0 = encrypt, 1 = decrypt, sampled with START
//   DIN[0:63]  : L0||R0 after the initial permutation
//   KEY[0:55]  : C0||D0 after PC-1
//   READY      : controller idle and able to accept START
//   F_R[0:31]  : current R half, goes to the external round function
//   F_CD[0:55] : current rotated C||D, goes to the external PC-2
//   F_OUT[0:31]: combinational round-function result for F_R/F_CD
//   ROUND_IDX  : round number minus 1 while in a round, otherwise 0
//   DOUT[0:63] : pre-output R16||L16
//   DOUT_VALID : DOUT holds a finished result
//   DOUT_ACK   : consumer accepts DOUT
// -----------------------------------------------------------------------------
interface des_round_ctrl_if;
   logic        START;
   logic        MODE;
   logic [0:63] DIN;
   logic [0:55] KEY;
   logic        READY;
   logic [0:31] F_R;
   logic [0:55] F_CD;
   logic [0:31] F_OUT;
   logic [3:0]  ROUND_IDX;
   logic [0:63] DOUT;
   logic        DOUT_VALID;
   logic        DOUT_ACK;

   modport master (
      output START, MODE, DIN, KEY, F_OUT, DOUT_ACK,
      input  READY, F_R, F_CD, ROUND_IDX, DOUT, DOUT_VALID
   );

   modport slave (
      input  START, MODE, DIN, KEY, F_OUT, DOUT_ACK,
      output READY, F_R, F_CD, ROUND_IDX, DOUT, DOUT_VALID
   );
endinterface

// File: rtl/des_round_ctrl.sv
// -----------------------------------------------------------------------------
// des_round_ctrl
// Sequences the 16 DES Feistel rounds over an externally supplied round
// function. The controller holds the L/R halves and the rotating C/D key
// register, and it presents R and C||D to the outside. It takes back
// f(R, PC-2(C||D)) in the same cycle. It runs one round per clock and then
// holds R16||L16 until the consumer acknowledges it.
//
// Ports
//   CLK : clock, all state changes on the rising edge
//   RST : asynchronous, active-high reset; clears every register
//   bus : des_round_ctrl_if.slave (START/MODE/DIN/KEY in, READY out,
//         F_R/F_CD out, F_OUT in, ROUND_IDX out, DOUT/DOUT_VALID out,
//         DOUT_ACK in)
// -----------------------------------------------------------------------------
module des_round_ctrl (
   input  logic              CLK,
   input  logic              RST,
   des_round_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t      state_q;
   logic [0:31] l_q;
   logic [0:31] r_q;
   logic [0:55] cd_q;
   logic [3:0]  cnt_q;
   logic        mode_q;
   logic [0:63] dout_q;
   logic        vld_q;
   logic        ready_q;

   logic [0:31] r_d;
   logic [0:55] cd_d;
   logic [4:0]  k_enc;
   logic [4:0]  k_dec;

   // DES left-shift schedule s[k], k = 1..16.
   function automatic logic [1:0] shift_amt(input logic [4:0] k);
      case (k)
         5'd1, 5'd2, 5'd9, 5'd16: shift_amt = 2'd1;
         default:                 shift_amt = 2'd2;
      endcase
   endfunction

   // Rotate one 28-bit half by 1 or 2. Index 0 is the leftmost bit.
   function automatic logic [0:27] rot28(input logic [0:27] x, input logic right,
                                         input logic [1:0] n);
      case ({right, n})
         3'b001:  rot28 = {x[1:27], x[0]};
         3'b010:  rot28 = {x[2:27], x[0:1]};
         3'b101:  rot28 = {x[27], x[0:26]};
         3'b110:  rot28 = {x[26:27], x[0:25]};
         default: rot28 = x;
      endcase
   endfunction

   function automatic logic [0:55] rot_cd(input logic [0:55] cd, input logic right,
                                          input logic [1:0] n);
      rot_cd = {rot28(cd[0:27], right, n), rot28(cd[28:55], right, n)};
   endfunction

   // The register already holds the key for round counter+1. Prepare the key
   // for round k = counter+2. Encryption rotates left by s[k]. Decryption
   // walks the schedule backwards: it rotates right by s[18-k], which is
   // s[16-counter].
   always_comb begin
      k_enc = {1'b0, cnt_q} + 5'd2;
      k_dec = 5'd16 - {1'b0, cnt_q};
      r_d   = l_q ^ bus.F_OUT;
      if (mode_q) cd_d = rot_cd(cd_q, 1'b1, shift_amt(k_dec));
      else        cd_d = rot_cd(cd_q, 1'b0, shift_amt(k_enc));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         cd_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.START) begin
                  l_q     <= bus.DIN[0:31];
                  r_q     <= bus.DIN[32:63];
                  cnt_q   <= '0;
                  mode_q  <= bus.MODE;
                  // Encryption round 1 uses C1/D1, which is one left shift
                  // of the key. Decryption round 1 uses K16, and K16 is the
                  // unrotated key because the rotations total 28.
                  cd_q    <= bus.MODE ? bus.KEY : rot_cd(bus.KEY, 1'b0, 2'd1);
                  ready_q <= 1'b0;
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               l_q   <= r_q;
               r_q   <= r_d;
               // On the last round the counter wraps from 15 to 0, so
               // ROUND_IDX reads 0 in DONE without a separate clear.
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  // Pre-output swap: R16 goes first.
                  dout_q  <= {r_d, r_q};
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cd_q <= cd_d;
               end
            end
            DONE: begin
               if (bus.DOUT_ACK) begin
                  vld_q   <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.READY      = ready_q;
   assign bus.F_R        = r_q;
   assign bus.F_CD       = cd_q;
   assign bus.ROUND_IDX  = cnt_q;
   assign bus.DOUT       = dout_q;
   assign bus.DOUT_VALID = vld_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_round_ctrl
// Bench for des_round_ctrl. The bench plays the external round function: it
// computes F_OUT as the full DES f applied to F_R and PC-2(F_CD). The
// reference model works from the textbook description of DES. It builds each
// subkey from the cumulative shift total, reverses the subkey order for
// decryption, and runs the Feistel iteration directly. The model predicts the
// per-round F_R/F_CD/ROUND_IDX and the final R16||L16.
// -----------------------------------------------------------------------------
module tb_des_round_ctrl;

   logic clk = 1'b0;
   logic rst;

   des_round_ctrl_if bus ();

   des_round_ctrl dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                    23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                    41,52,31,37,47,55,30,40,51,45,33,48,
                    44,49,39,56,34,53,46,42,50,36,29,32};

   int PT [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                    2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

   int SB [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
   };

   logic [0:55] exp_cd [1:16];
   logic [0:31] exp_r  [0:15];

   // DES f: expansion, key mixing, S-boxes, P permutation.
   function automatic logic [0:31] des_f(input logic [0:31] r, input logic [0:55] cd);
      logic [0:47] x;
      logic [0:31] s;
      logic [0:31] p;
      int row, col, v;
      for (int i = 0; i < 48; i++)
         x[i] = r[(4 * (i / 6) + (i % 6) + 31) % 32] ^ cd[PC2[i] - 1];
      for (int j = 0; j < 8; j++) begin
         row = 2 * int'(x[6*j]) + int'(x[6*j+5]);
         col = 8 * int'(x[6*j+1]) + 4 * int'(x[6*j+2]) + 2 * int'(x[6*j+3]) + int'(x[6*j+4]);
         v   = SB[j][row * 16 + col];
         for (int b = 0; b < 4; b++) s[4*j+b] = v[3-b];
      end
      for (int i = 0; i < 32; i++) p[i] = s[PT[i] - 1];
      return p;
   endfunction

   always_comb bus.F_OUT = des_f(bus.F_R, bus.F_CD);

   function automatic logic [0:27] rotl28(input logic [0:27] x, input int n);
      int m;
      m = n % 28;
      if (m == 0) return x;
      return (x << m) | (x >> (28 - m));
   endfunction

   task automatic model(input logic [0:63] din, input logic [0:55] key, input logic mode,
                        output logic [0:63] res);
      logic [0:55] sub [1:16];
      logic [0:31] l, r, t;
      int tot;
      tot = 0;
      for (int i = 1; i <= 16; i++) begin
         tot += SHIFTS[i-1];
         sub[i] = {rotl28(key[0:27], tot), rotl28(key[28:55], tot)};
      end
      for (int i = 1; i <= 16; i++) exp_cd[i] = mode ? sub[17-i] : sub[i];
      l = din[0:31];
      r = din[32:63];
      for (int i = 1; i <= 16; i++) begin
         exp_r[i-1] = r;
         t = r;
         r = l ^ des_f(r, exp_cd[i]);
         l = t;
      end
      res = {r, l};
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with the DUT idle. START is raised here, so the
   // next rising edge is the accepting edge (edge 1) and edge 17 must deliver
   // DOUT_VALID. If abort_at is nonzero, reset is pulsed between edges during
   // that round and the block is abandoned.
   task automatic run_block(input logic [0:63] din, input logic [0:55] key, input logic mode,
                            input int hold, input int abort_at, output logic [0:63] got);
      logic [0:63] exp;
      logic [0:63] held;
      model(din, key, mode, exp);
      chk("ready_idle", 64'(bus.READY), 64'd1);
      bus.START = 1'b1;
      bus.MODE  = mode;
      bus.DIN   = din;
      bus.KEY   = key;
      @(negedge clk);
      bus.START = 1'b0;
      bus.MODE  = 1'($urandom);
      bus.DIN   = {$urandom, $urandom};
      bus.KEY   = 56'({$urandom, $urandom});
      for (int rnd = 1; rnd <= 16; rnd++) begin
         chk("round_idx",  64'(bus.ROUND_IDX),  64'(rnd - 1));
         chk("f_cd",       64'(bus.F_CD),       64'(exp_cd[rnd]));
         chk("f_r",        64'(bus.F_R),        64'(exp_r[rnd-1]));
         chk("ready_busy", 64'(bus.READY),      64'd0);
         chk("valid_busy", 64'(bus.DOUT_VALID), 64'd0);
         if (rnd == abort_at) begin
            bus.START    = 1'b0;
            bus.DOUT_ACK = 1'b0;
            #2 rst = 1'b1;
            #1;
            chk("rst_ready", 64'(bus.READY),      64'd1);
            chk("rst_valid", 64'(bus.DOUT_VALID), 64'd0);
            chk("rst_idx",   64'(bus.ROUND_IDX),  64'd0);
            chk("rst_dout",  64'(bus.DOUT),       64'd0);
            chk("rst_fr",    64'(bus.F_R),        64'd0);
            chk("rst_fcd",   64'(bus.F_CD),       64'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 18; c++) begin
               @(negedge clk);
               chk("no_valid_after_rst", 64'(bus.DOUT_VALID), 64'd0);
               chk("idle_after_rst",     64'(bus.READY),      64'd1);
            end
            got = '0;
            return;
         end
         bus.START    = 1'($urandom);
         bus.DOUT_ACK = 1'($urandom);
         @(negedge clk);
      end
      bus.START    = 1'b0;
      bus.DOUT_ACK = 1'b0;
      chk("valid_done", 64'(bus.DOUT_VALID), 64'd1);
      chk("dout",       64'(bus.DOUT),       64'(exp));
      chk("ready_done", 64'(bus.READY),      64'd0);
      chk("idx_done",   64'(bus.ROUND_IDX),  64'd0);
      got  = bus.DOUT;
      held = exp;
      for (int c = 0; c < hold; c++) begin
         bus.START = 1'($urandom);
         bus.MODE  = 1'($urandom);
         bus.DIN   = {$urandom, $urandom};
         @(negedge clk);
         chk("bp_valid", 64'(bus.DOUT_VALID), 64'd1);
         chk("bp_dout",  64'(bus.DOUT),       64'(held));
         chk("bp_ready", 64'(bus.READY),      64'd0);
      end
      // START coincident with the acknowledge must not start a block.
      bus.DOUT_ACK = 1'b1;
      bus.START    = 1'b1;
      @(negedge clk);
      bus.DOUT_ACK = 1'b0;
      bus.START    = 1'b0;
      chk("ack_ready", 64'(bus.READY),      64'd1);
      chk("ack_valid", 64'(bus.DOUT_VALID), 64'd0);
      chk("ack_dout",  64'(bus.DOUT),       64'(held));
      chk("ack_idx",   64'(bus.ROUND_IDX),  64'd0);
   endtask

   initial begin
      logic [0:63] got;
      logic [0:63] din;
      logic [0:63] ct;
      logic [0:55] key;
      rst          = 1'b0;
      bus.START    = 1'b0;
      bus.MODE     = 1'b0;
      bus.DIN      = '0;
      bus.KEY      = '0;
      bus.DOUT_ACK = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset_ready", 64'(bus.READY),      64'd1);
      chk("reset_valid", 64'(bus.DOUT_VALID), 64'd0);
      chk("reset_dout",  64'(bus.DOUT),       64'd0);
      chk("reset_idx",   64'(bus.ROUND_IDX),  64'd0);
      chk("reset_fr",    64'(bus.F_R),        64'd0);
      chk("reset_fcd",   64'(bus.F_CD),       64'd0);

      // Release reset and raise START together: the first edge with RST low
      // accepts the block.
      @(negedge clk);
      rst = 1'b0;
      key = {28'hF0CCAAF, 28'h556678F};
      run_block(64'hCC00CCFF_F0AAF0AA, key, 1'b0, 10, 0, got);
      chk("kat_enc_dout", 64'(got), 64'h0A4CD995_43423234);

      // Immediately after the return to IDLE: decrypt the pre-output back.
      run_block(64'h0A4CD995_43423234, key, 1'b1, 0, 0, got);
      chk("kat_dec_dout", 64'(got), 64'hCC00CCFF_F0AAF0AA);

      // Reset in the middle of round 7, then a fresh block.
      run_block({$urandom, $urandom}, 56'({$urandom, $urandom}), 1'b0, 0, 7, got);
      run_block({$urandom, $urandom}, 56'({$urandom, $urandom}), 1'($urandom), 2, 0, got);

      // Random encrypt/decrypt round trips.
      for (int n = 0; n < 4; n++) begin
         din = {$urandom, $urandom};
         key = 56'({$urandom, $urandom});
         model(din, key, 1'b0, ct);
         run_block(din, key, 1'b0, int'($urandom_range(0, 3)), 0, got);
         run_block(ct, key, 1'b1, int'($urandom_range(0, 3)), 0, got);
         chk("roundtrip", 64'(got), 64'(din));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
